// File: rtl/inverter_unit_if.sv
// inverter_unit_if: data, enable and status signals of the inverter cell
interface inverter_unit_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] b_q;
  logic en;
  logic b_valid;
  logic a_changed;
  logic [CNT_W-1:0] toggle_cnt;
  modport master (output a, en, input b, b_q, b_valid, a_changed, toggle_cnt);
  modport slave (input a, en, output b, b_q, b_valid, a_changed, toggle_cnt);
endinterface

// File: rtl/inverter_unit.sv
// inverter_unit: combinational and registered bitwise inverter with input-change monitor
module inverter_unit #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst_n,
  inverter_unit_if.slave bus
);
  logic [WIDTH-1:0] bq_q, bq_d, a_prev_q;
  logic valid_q, valid_d, chg_q, chg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    chg_d = bus.a != a_prev_q;
    bq_d = bus.en ? ~bus.a : bq_q;
    valid_d = bus.en | valid_q;
    cnt_d = (chg_d && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bq_q <= '1;
      valid_q <= 1'b0;
      a_prev_q <= '0;
      chg_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      bq_q <= bq_d;
      valid_q <= valid_d;
      a_prev_q <= bus.a;
      chg_q <= chg_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.b = ~bus.a;
  assign bus.b_q = bq_q;
  assign bus.b_valid = valid_q;
  assign bus.a_changed = chg_q;
  assign bus.toggle_cnt = cnt_q;
endmodule

// File: tb/tb_inverter_unit.sv
// tb_inverter_unit: directed checks of inverter_unit, including a 2-bit counter instance for saturation
module tb_inverter_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  inverter_unit_if #(.WIDTH(1), .CNT_W(8)) bus ();
  inverter_unit_if #(.WIDTH(1), .CNT_W(2)) sbus ();
  inverter_unit #(.WIDTH(1), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  inverter_unit #(.WIDTH(1), .CNT_W(2)) u_sat (.clk(clk), .rst_n(rst_n), .bus(sbus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    bus.a = 1'b0; bus.en = 1'b0; sbus.a = 1'b0; sbus.en = 1'b0;
    #5 chk("comb_b_a0", 32'(bus.b), 32'd1);
    bus.a = 1'b1;
    #5 chk("comb_b_a1", 32'(bus.b), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    step(); step();
    chk("rst_bq", 32'(bus.b_q), 32'd1);
    chk("rst_valid", 32'(bus.b_valid), 32'd0);
    chk("rst_cnt", 32'(bus.toggle_cnt), 32'd0);
    chk("rst_chg", 32'(bus.a_changed), 32'd0);
    chk("rst_b", 32'(bus.b), 32'd0);
    rst_n = 1'b1; bus.en = 1'b1; bus.a = 1'b1;
    step();
    chk("cap_bq", 32'(bus.b_q), 32'd0);
    chk("cap_valid", 32'(bus.b_valid), 32'd1);
    chk("cap_first_chg", 32'(bus.a_changed), 32'd1);
    chk("cap_cnt", 32'(bus.toggle_cnt), 32'd1);
    bus.en = 1'b0; bus.a = 1'b0;
    step();
    chk("hold_bq", 32'(bus.b_q), 32'd0);
    chk("hold_valid", 32'(bus.b_valid), 32'd1);
    chk("hold_b", 32'(bus.b), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; bus.en = 1'b1; bus.a = 1'b0;
    step();
    chk("seq0_chg", 32'(bus.a_changed), 32'd0);
    bus.a = 1'b1;
    step();
    chk("seq1_chg", 32'(bus.a_changed), 32'd1);
    chk("seq1_bq", 32'(bus.b_q), 32'd0);
    bus.a = 1'b1;
    step();
    chk("seq2_chg", 32'(bus.a_changed), 32'd0);
    bus.a = 1'b0;
    step();
    chk("seq3_chg", 32'(bus.a_changed), 32'd1);
    chk("seq_cnt", 32'(bus.toggle_cnt), 32'd2);
    chk("seq_valid", 32'(bus.b_valid), 32'd1);
    chk("seq_bq", 32'(bus.b_q), 32'd1);
    rst_n = 1'b0; bus.a = 1'b1;
    step();
    chk("mid_bq", 32'(bus.b_q), 32'd1);
    chk("mid_valid", 32'(bus.b_valid), 32'd0);
    chk("mid_chg", 32'(bus.a_changed), 32'd0);
    chk("mid_cnt", 32'(bus.toggle_cnt), 32'd0);
    chk("mid_b1", 32'(bus.b), 32'd0);
    bus.a = 1'b0;
    #1 chk("mid_b0", 32'(bus.b), 32'd1);
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      sbus.a = ~sbus.a;
      step();
      chk($sformatf("sat_cnt%0d", i), 32'(sbus.toggle_cnt), (i < 3) ? 32'(i) : 32'd3);
      chk($sformatf("sat_chg%0d", i), 32'(sbus.a_changed), 32'd1);
    end
    chk("sat_valid", 32'(sbus.b_valid), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
